config_frame_loader: RTL and testbench
======================================

// Module: config_frame_loader
// PURPOSE
//  Consumes 32-bit configuration words and strobes produced by the JTAG config deserialiser.
//  Assembles them into complete configuration frames: one header word, then WORDS_PER_FRAME data words.
//  Presents each finished frame, with its frame address, to the fabric frame-write logic as a 1-cycle commit.
//  Sits between the JTAG deserialiser and the frame register array; monitors the deserialiser's finished flag.
// PARAMETERS
//  WORDS_PER_FRAME  4      data words per frame; frame_data width = 32*WORDS_PER_FRAME
//  FRAME_ADDR_W     5      frame address width, taken from header bits [FRAME_ADDR_W-1:0]
//  TIMEOUT          1023   max clk cycles between strobes inside a frame before abort (>=64)
// PORTS
//  clk          in   1                  system clock, rising edge
//  reset        in   1                  synchronous, active-low
//  word_in      in   32                 config word from deserialiser
//  word_strobe  in   1                  word_in valid, 1-cycle pulse
//  cfg_finished in   1                  deserialiser finished flag (level)
//  frame_data   out  32*WORDS_PER_FRAME assembled frame; first data word in MSBs
//  frame_addr   out  FRAME_ADDR_W       address of committed frame
//  frame_strobe out  1                  1-cycle pulse; frame_data/frame_addr valid, held until next commit
//  busy         out  1                  1 while in LOAD or COMMIT
//  loader_done  out  1                  sticky, set on entry to DONE
//  error_count  out  8                  saturating count of rejected headers and timeouts
//  frame_count  out  16                 committed frames, wraps at 2^16
// BEHAVIOUR
//  Reset (reset==0 at clk edge): state=IDLE; all outputs, buffers and counters = 0.
//  States: IDLE, LOAD, COMMIT, DONE.
//  IDLE, word_strobe=1, word_in[31:28] decoded:
//   4'hC: latch addr=word_in[FRAME_ADDR_W-1:0]; word_cnt=0; tmo=0; -> LOAD.
//   4'hF: -> DONE.
//   other: error_count+1 (saturate 255); stay IDLE.
//  LOAD:
//   - strobe: buffer <= {buffer[32*WORDS_PER_FRAME-33:0], word_in}; tmo=0.
//   - if word_cnt==WORDS_PER_FRAME-1 on strobe -> COMMIT; else word_cnt+1.
//   - Data words are never header-decoded.
//   - No strobe: tmo+1. tmo==TIMEOUT-1 -> discard partial frame, error_count+1, -> IDLE.
//  COMMIT (exactly 1 cycle):
//   - frame_data<=buffer; frame_addr<=addr; frame_strobe=1 on next cycle; frame_count+1; -> IDLE.
//   - A strobe arriving in COMMIT is header-decoded exactly as in IDLE (no word lost).
//   - Latency: frame_strobe high 2 clk after the strobe of the last data word.
//  cfg_finished=1 in IDLE or LOAD: -> DONE. Priority over word_strobe in that cycle.
//   Partial frame discarded, no error counted.
//  cfg_finished=1 in COMMIT: commit completes, then -> DONE.
//  DONE: loader_done=1, busy=0; all strobes ignored; left only by reset.
//  Reset mid-frame: partial frame lost; frame_data/frame_addr cleared to 0; no frame_strobe.
//  frame_strobe never asserts for two consecutive cycles.
// TESTING (WORDS_PER_FRAME=4, FRAME_ADDR_W=5)
//  1. Basic: strobes C0000003, 11111111, 22222222, 33333333, 44444444 (gaps of 40 clk)
//     -> single frame_strobe; frame_addr=3; frame_data=0x11111111_22222222_33333333_44444444; frame_count=1.
//  2. Bad header: strobe 0xDEADBEEF in IDLE -> error_count=1, no LOAD.
//     Then a valid frame -> committed normally.
//  3. Timeout: header C0000007 + 2 data words, then silence TIMEOUT clk
//     -> error_count+1, back to IDLE, no frame_strobe.
//     Then a full frame to addr 7 commits correct data.
//  4. Abort: cfg_finished=1 after 2 data words -> loader_done=1, no frame_strobe, error_count unchanged.
//     Further strobes ignored.
//  5. Back-to-back: next header strobed in the COMMIT cycle -> first frame commits, second frame loads.
//     frame_count=2 after both.
//  6. Reset mid-LOAD: reset low 1 clk after 3rd data word -> all outputs 0.
//     Fresh frame to addr 31 commits with frame_addr=31.

Source files
------------

// File: rtl/config_frame_loader_if.sv
// Deserialiser-to-loader word stream and loader-to-fabric frame commit bundle.
// master = word source / frame sink, slave = config_frame_loader.
interface config_frame_loader_if #(
   parameter int WORDS_PER_FRAME = 4,
   parameter int FRAME_ADDR_W    = 5
);
   logic [31:0]                   word_in;
   logic                          word_strobe;
   logic                          cfg_finished;
   logic [32*WORDS_PER_FRAME-1:0] frame_data;
   logic [FRAME_ADDR_W-1:0]       frame_addr;
   logic                          frame_strobe;
   logic                          busy;
   logic                          loader_done;
   logic [7:0]                    error_count;
   logic [15:0]                   frame_count;

   modport master (
      output word_in, word_strobe, cfg_finished,
      input  frame_data, frame_addr, frame_strobe, busy, loader_done, error_count, frame_count
   );

   modport slave (
      input  word_in, word_strobe, cfg_finished,
      output frame_data, frame_addr, frame_strobe, busy, loader_done, error_count, frame_count
   );
endinterface

// File: rtl/config_frame_loader.sv
// Assembles header + WORDS_PER_FRAME data words into a frame and commits it
// to the frame-write logic with a 1-cycle strobe.
module config_frame_loader #(
   parameter int WORDS_PER_FRAME = 4,
   parameter int FRAME_ADDR_W    = 5,
   parameter int TIMEOUT         = 1023
) (
   input logic                  clk,
   input logic                  reset,
   config_frame_loader_if.slave bus
);
   localparam int FW    = 32*WORDS_PER_FRAME;
   localparam int CNT_W = (WORDS_PER_FRAME > 1) ? $clog2(WORDS_PER_FRAME) : 1;
   localparam int TMO_W = $clog2(TIMEOUT);

   typedef enum logic [1:0] {IDLE, LOAD, COMMIT, DONE} state_t;

   state_t                  state_q, state_d;
   logic [FRAME_ADDR_W-1:0] addr_q, addr_d;
   logic [CNT_W-1:0]        word_cnt_q, word_cnt_d;
   logic [TMO_W-1:0]        tmo_q, tmo_d;
   logic [FW-1:0]           buf_q, buf_d;
   logic [FW-1:0]           frame_data_q, frame_data_d;
   logic [FRAME_ADDR_W-1:0] frame_addr_q, frame_addr_d;
   logic                    frame_strobe_q, frame_strobe_d;
   logic                    busy_q, busy_d;
   logic                    loader_done_q, loader_done_d;
   logic [7:0]              error_count_q, error_count_d;
   logic [15:0]             frame_count_q, frame_count_d;
   logic                    err_inc;

   always_comb begin
      state_d        = state_q;
      addr_d         = addr_q;
      word_cnt_d     = word_cnt_q;
      tmo_d          = tmo_q;
      buf_d          = buf_q;
      frame_data_d   = frame_data_q;
      frame_addr_d   = frame_addr_q;
      frame_strobe_d = 1'b0;
      frame_count_d  = frame_count_q;
      err_inc        = 1'b0;
      case (state_q)
         IDLE, COMMIT: begin
            if (state_q == COMMIT) begin
               frame_data_d   = buf_q;
               frame_addr_d   = addr_q;
               frame_strobe_d = 1'b1;
               frame_count_d  = frame_count_q + 16'd1;
               state_d        = IDLE;
            end
            // COMMIT also decodes headers so a strobe right after the last data word is not lost
            if (bus.cfg_finished) begin
               state_d = DONE;
            end else if (bus.word_strobe) begin
               case (bus.word_in[31:28])
                  4'hC: begin
                     addr_d     = bus.word_in[FRAME_ADDR_W-1:0];
                     word_cnt_d = '0;
                     tmo_d      = '0;
                     state_d    = LOAD;
                  end
                  4'hF:    state_d = DONE;
                  default: err_inc = 1'b1;
               endcase
            end
         end
         LOAD: begin
            if (bus.cfg_finished) begin
               state_d = DONE;
            end else if (bus.word_strobe) begin
               buf_d = FW'(buf_q << 32) | FW'(bus.word_in);
               tmo_d = '0;
               if (word_cnt_q == CNT_W'(WORDS_PER_FRAME-1)) state_d = COMMIT;
               else word_cnt_d = word_cnt_q + CNT_W'(1);
            end else if (tmo_q == TMO_W'(TIMEOUT-1)) begin
               err_inc = 1'b1;
               state_d = IDLE;
            end else begin
               tmo_d = tmo_q + TMO_W'(1);
            end
         end
         default: ;
      endcase
      error_count_d = (err_inc && error_count_q != 8'hFF) ? error_count_q + 8'd1 : error_count_q;
      busy_d        = (state_d == LOAD) || (state_d == COMMIT);
      loader_done_d = loader_done_q || (state_d == DONE);
   end

   always_ff @(posedge clk) begin
      if (!reset) begin
         state_q        <= IDLE;
         addr_q         <= '0;
         word_cnt_q     <= '0;
         tmo_q          <= '0;
         buf_q          <= '0;
         frame_data_q   <= '0;
         frame_addr_q   <= '0;
         frame_strobe_q <= 1'b0;
         busy_q         <= 1'b0;
         loader_done_q  <= 1'b0;
         error_count_q  <= '0;
         frame_count_q  <= '0;
      end else begin
         state_q        <= state_d;
         addr_q         <= addr_d;
         word_cnt_q     <= word_cnt_d;
         tmo_q          <= tmo_d;
         buf_q          <= buf_d;
         frame_data_q   <= frame_data_d;
         frame_addr_q   <= frame_addr_d;
         frame_strobe_q <= frame_strobe_d;
         busy_q         <= busy_d;
         loader_done_q  <= loader_done_d;
         error_count_q  <= error_count_d;
         frame_count_q  <= frame_count_d;
      end
   end

   assign bus.frame_data   = frame_data_q;
   assign bus.frame_addr   = frame_addr_q;
   assign bus.frame_strobe = frame_strobe_q;
   assign bus.busy         = busy_q;
   assign bus.loader_done  = loader_done_q;
   assign bus.error_count  = error_count_q;
   assign bus.frame_count  = frame_count_q;
endmodule

// File: tb/tb_config_frame_loader.sv
// Bench for config_frame_loader: directed scenarios plus randomized frames,
// frame commits checked by a scoreboard fed from a transaction-level model.
module tb_config_frame_loader;
   localparam int W       = 4;
   localparam int AW      = 5;
   localparam int TIMEOUT = 1023;

   logic clk = 1'b0;
   logic reset;
   always #5 clk = ~clk;

   config_frame_loader_if #(.WORDS_PER_FRAME(W), .FRAME_ADDR_W(AW)) bus ();

   config_frame_loader #(.WORDS_PER_FRAME(W), .FRAME_ADDR_W(AW), .TIMEOUT(TIMEOUT)) dut (
      .clk  (clk),
      .reset(reset),
      .bus  (bus)
   );

   typedef struct {
      logic [AW-1:0]   addr;
      logic [32*W-1:0] data;
      int              edge_e;
      int              cnt;
   } exp_t;
   typedef enum {M_IDLE, M_LOAD, M_DONE} mode_t;

   exp_t        exp_q[$];
   logic [31:0] words[$];
   mode_t       mode;
   logic [AW-1:0] m_addr;
   int          m_err, m_frames, last_strobe, commit_e;
   int          edge_n = 0;
   int          passed = 0, total = 0;

   task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
      total++;
      if (act === exp) passed++;
      else $display("FAIL %s: got %h expected %h", nm, act, exp);
   endtask

   // Transaction-level reference: E is the clock edge that samples these inputs.
   task automatic model_step(input int e, input logic rn, input logic st, input logic [31:0] w,
                             input logic fin);
      exp_t x;
      if (!rn) begin
         mode = M_IDLE; m_err = 0; m_frames = 0; commit_e = -10; words.delete();
         while (exp_q.size() > 0 && exp_q[$].edge_e >= e) void'(exp_q.pop_back());
         return;
      end
      if (mode == M_DONE) return;
      if (fin) begin mode = M_DONE; words.delete(); return; end
      if (mode == M_LOAD && !st && e - last_strobe == TIMEOUT) begin
         if (m_err < 255) m_err++;
         mode = M_IDLE;
         return;
      end
      if (!st) return;
      last_strobe = e;
      if (mode == M_LOAD) begin
         words.push_back(w);
         if (words.size() == W) begin
            x.data = '0;
            for (int i = 0; i < W; i++) x.data[32*W-1-32*i -: 32] = words[i];
            m_frames = (m_frames + 1) % 65536;
            x.addr = m_addr; x.edge_e = e + 1; x.cnt = m_frames;
            exp_q.push_back(x);
            commit_e = e;
            mode = M_IDLE;
         end
      end else begin
         case (w[31:28])
            4'hC: begin m_addr = w[AW-1:0]; words.delete(); mode = M_LOAD; end
            4'hF: mode = M_DONE;
            default: if (m_err < 255) m_err++;
         endcase
      end
   endtask

   task automatic check_status();
      chk("busy", 128'(bus.busy), 128'((mode == M_LOAD) || (commit_e == edge_n)));
      chk("loader_done", 128'(bus.loader_done), 128'(mode == M_DONE));
      chk("error_count", 128'(bus.error_count), 128'(m_err));
   endtask

   task automatic tick(input logic rn, input logic st, input logic [31:0] w, input logic fin);
      reset = rn; bus.word_strobe = st; bus.word_in = st ? w : 32'h0; bus.cfg_finished = fin;
      model_step(edge_n + 1, rn, st, w, fin);
      @(posedge clk);
      edge_n++;
      #1;
      check_status();
   endtask

   task automatic idle(input int n);
      repeat (n) tick(1'b1, 1'b0, 32'h0, 1'b0);
   endtask

   task automatic word(input logic [31:0] w, input int gap);
      tick(1'b1, 1'b1, w, 1'b0);
      idle(gap);
   endtask

   task automatic check_zero(input string nm);
      chk({nm, "_data"}, bus.frame_data, 128'h0);
      chk({nm, "_addr"}, 128'(bus.frame_addr), 128'h0);
      chk({nm, "_strobe"}, 128'(bus.frame_strobe), 128'h0);
      chk({nm, "_fcount"}, 128'(bus.frame_count), 128'h0);
   endtask

   function automatic logic [31:0] rand_data();
      logic [31:0] w;
      w = $urandom();
      if ($urandom_range(0, 3) == 0) w[31:28] = ($urandom_range(0, 1) == 1) ? 4'hC : 4'hF;
      return w;
   endfunction

   // Scoreboard monitor: pops one expected frame per observed commit.
   bit prev_fs = 1'b0;
   always @(negedge clk) begin
      exp_t x;
      if (bus.frame_strobe) begin
         chk("strobe_not_consecutive", 128'(prev_fs), 128'h0);
         if (exp_q.size() == 0) begin
            chk("unexpected_commit", 128'(1), 128'(0));
         end else begin
            x = exp_q.pop_front();
            chk("frame_addr", 128'(bus.frame_addr), 128'(x.addr));
            chk("frame_data", bus.frame_data, x.data);
            chk("commit_edge", 128'(edge_n), 128'(x.edge_e));
            chk("frame_count", 128'(bus.frame_count), 128'(x.cnt));
         end
      end
      prev_fs = bus.frame_strobe;
   end

   initial begin
      #5_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   initial begin
      logic [31:0] w;
      reset = 1'b0; bus.word_strobe = 1'b0; bus.word_in = '0; bus.cfg_finished = 1'b0;
      repeat (3) tick(1'b0, 1'b0, 32'h0, 1'b0);
      check_zero("reset");

      // basic frame
      word(32'hC000_0003, 40); word(32'h1111_1111, 40); word(32'h2222_2222, 40);
      word(32'h3333_3333, 40); word(32'h4444_4444, 40);
      chk("t1_data", bus.frame_data, 128'h11111111_22222222_33333333_44444444);
      chk("t1_addr", 128'(bus.frame_addr), 128'd3);
      chk("t1_count", 128'(bus.frame_count), 128'd1);

      // bad header then a valid frame
      word(32'hDEAD_BEEF, 5);
      chk("t2_err", 128'(bus.error_count), 128'd1);
      chk("t2_busy", 128'(bus.busy), 128'd0);
      word(32'hC000_0005, 2);
      for (int i = 0; i < W; i++) word(rand_data(), 2);
      idle(3);
      chk("t2_count", 128'(bus.frame_count), 128'd2);

      // timeout, then a gap one short of the timeout that must survive
      word(32'hC000_0007, 1); word(32'hAAAA_0001, 1); word(32'hAAAA_0002, TIMEOUT);
      idle(2);
      chk("t3_err", 128'(bus.error_count), 128'd2);
      chk("t3_count", 128'(bus.frame_count), 128'd2);
      word(32'hC000_0007, TIMEOUT - 1);
      word(32'h7000_0001, TIMEOUT - 1); word(32'h7000_0002, 0);
      word(32'h7000_0003, 0); word(32'h7000_0004, 3);
      chk("t3_data", bus.frame_data, 128'h70000001_70000002_70000003_70000004);
      chk("t3_addr", 128'(bus.frame_addr), 128'd7);

      // back-to-back: next header lands in the commit cycle
      word(32'hC000_0001, 0);
      for (int i = 0; i < W; i++) word(32'h1000_0000 + i, 0);
      word(32'hC000_0002, 0);
      for (int i = 0; i < W; i++) word(32'h2000_0000 + i, 0);
      idle(3);
      chk("t5_count", 128'(bus.frame_count), 128'd5);
      chk("t5_addr", 128'(bus.frame_addr), 128'd2);

      // randomized traffic
      for (int n = 0; n < 40; n++) begin
         int r;
         r = $urandom_range(0, 19);
         if (r == 0) begin
            w = $urandom();
            while (w[31:28] == 4'hC || w[31:28] == 4'hF) w = $urandom();
            word(w, $urandom_range(0, 3));
         end else if (r == 1) begin
            w = $urandom(); w[31:28] = 4'hC;
            word(w, $urandom_range(0, 2));
            repeat ($urandom_range(0, W - 1)) word(rand_data(), $urandom_range(0, 2));
            idle(TIMEOUT + 1);
         end else begin
            w = $urandom(); w[31:28] = 4'hC;
            word(w, $urandom_range(0, 3));
            for (int i = 0; i < W; i++) word(rand_data(), $urandom_range(0, 3));
         end
      end
      idle(4);

      // reset mid-load, then a fresh frame to the top address
      word(32'hC000_0009, 2); word(32'h9000_0001, 2); word(32'h9000_0002, 2);
      word(32'h9000_0003, 1);
      tick(1'b0, 1'b0, 32'h0, 1'b0);
      check_zero("t6_reset");
      chk("t6_busy", 128'(bus.busy), 128'd0);
      chk("t6_err", 128'(bus.error_count), 128'd0);
      word(32'hC000_001F, 1);
      for (int i = 0; i < W; i++) word(32'h3100_0000 + i, 1);
      idle(2);
      chk("t6_addr", 128'(bus.frame_addr), 128'd31);
      chk("t6_count", 128'(bus.frame_count), 128'd1);

      // error counter saturation
      for (int i = 0; i < 260; i++) word(32'h1234_5678, 0);
      idle(2);
      chk("sat_err", 128'(bus.error_count), 128'd255);

      // abort with cfg_finished mid-frame; later strobes ignored
      word(32'hC000_0004, 2); word(32'h4000_0001, 2); word(32'h4000_0002, 2);
      tick(1'b1, 1'b0, 32'h0, 1'b1);
      idle(2);
      chk("t4_done", 128'(bus.loader_done), 128'd1);
      chk("t4_busy", 128'(bus.busy), 128'd0);
      chk("t4_err", 128'(bus.error_count), 128'd255);
      word(32'hC000_0006, 1);
      for (int i = 0; i < W; i++) word(32'h6000_0000 + i, 1);
      word(32'hDEAD_BEEF, 3);
      chk("t4_count", 128'(bus.frame_count), 128'd1);
      chk("t4_err_after", 128'(bus.error_count), 128'd255);

      idle(5);
      chk("pending_empty", 128'(exp_q.size()), 128'd0);
      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end
endmodule
